// File: rtl/keypad_decoder.sv
// Debounces whole-scan key bitmaps from the keypad scanner and emits one
// encoded event per physical press on a valid/ready handshake.
module keypad_decoder #(
    parameter int N_COLUMN       = 4,
    parameter int N_ROW          = 4,
    parameter int DEBOUNCE_SCANS = 3,
    localparam int N_KEYS        = N_COLUMN * N_ROW,
    localparam int CW            = $clog2(N_KEYS),
    localparam int DW            = $clog2(DEBOUNCE_SCANS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keys_in,
    input  logic              keys_valid,
    output logic [CW-1:0]     key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    state_t        state;
    logic [DW-1:0] cnt;
    logic [CW-1:0] cand;

    logic          scan_any;
    logic          scan_multi;
    logic [CW-1:0] scan_idx;
    logic          scan_none;
    logic          scan_single;
    logic [DW-1:0] cnt_next;
    logic          cnt_done;
    logic          accept;

    // Classify the scan; scan_idx is only meaningful when exactly one bit is set.
    always_comb begin
        scan_any   = 1'b0;
        scan_multi = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (keys_in[i]) begin
                if (scan_any) begin
                    scan_multi = 1'b1;
                end
                scan_any = 1'b1;
                scan_idx = CW'(i);
            end
        end
    end

    assign scan_none   = !scan_any;
    assign scan_single = scan_any && !scan_multi;
    assign cnt_next    = cnt + DW'(1);
    assign cnt_done    = (cnt_next == DW'(DEBOUNCE_SCANS));
    assign accept      = keys_valid && (state == PRESS_DB) && scan_single &&
                         (scan_idx == cand) && cnt_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (keys_valid) begin
                case (state)
                    IDLE: begin
                        if (scan_single) begin
                            state <= PRESS_DB;
                            cand  <= scan_idx;
                            cnt   <= DW'(1);
                        end else if (scan_multi) begin
                            state <= HELD;
                        end
                    end
                    PRESS_DB: begin
                        if (scan_single) begin
                            if (scan_idx == cand) begin
                                if (cnt_done) begin
                                    state <= HELD;
                                    cnt   <= '0;
                                end else begin
                                    cnt <= cnt_next;
                                end
                            end else begin
                                cand <= scan_idx;
                                cnt  <= DW'(1);
                            end
                        end else if (scan_none) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            state <= HELD;
                            cnt   <= '0;
                        end
                    end
                    HELD: begin
                        if (scan_none) begin
                            state <= RELEASE_DB;
                            cnt   <= DW'(1);
                        end
                    end
                    RELEASE_DB: begin
                        if (scan_none) begin
                            if (cnt_done) begin
                                state <= IDLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt_next;
                            end
                        end else begin
                            state <= HELD;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end

            // A new accept may replace an event only if that event is leaving this cycle.
            if (accept) begin
                if (!key_valid || key_ready) begin
                    key_code  <= cand;
                    key_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule
